// File: rtl/sc_pkg.sv
// Shared constants for the stochastic-computing datapath: default count width
// and the stream-to-binary FSM state encoding.
package sc_pkg;

  localparam int SC_COUNT_WIDTH = 8;

  localparam logic [1:0] SC_S2B_IDLE  = 2'd0;
  localparam logic [1:0] SC_S2B_ACCUM = 2'd1;
  localparam logic [1:0] SC_S2B_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S2B_IDLE  = SC_S2B_IDLE,
    S2B_ACCUM = SC_S2B_ACCUM,
    S2B_DONE  = SC_S2B_DONE
  } s2b_state_t;

endpackage

// File: rtl/sc_ones_counter.sv
// Counts one-bits of a stream: increments when enable and in are both high.
// Synchronous clear; reset and clear both return the count to zero.
module sc_ones_counter #(
  parameter int COUNT_WIDTH = sc_pkg::SC_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   in,
  output logic [COUNT_WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (enable && in) begin
      value <= value + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_stream_to_binary.sv
// Converts a unipolar stochastic bitstream to binary by counting ones over a
// window of len valid bits; count is presented with a one-cycle done pulse.
module sc_stream_to_binary
  import sc_pkg::*;
#(
  parameter int COUNT_WIDTH = SC_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic                   in,
  input  logic                   in_valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] count
);

  s2b_state_t             state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [COUNT_WIDTH-1:0] acc_value;
  logic                   acc_clear;
  logic                   acc_en;
  logic                   last_bit;

  // The window ends on the edge that samples the final valid bit.
  assign last_bit = (state_q == S2B_ACCUM) && in_valid && (remaining_q == COUNT_WIDTH'(1));

  sc_ones_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .enable (acc_en),
    .in     (in),
    .value  (acc_value)
  );

  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S2B_IDLE: begin
        if (start) begin
          acc_clear = 1'b1;
          state_d   = (len == '0) ? S2B_DONE : S2B_ACCUM;
        end
      end
      S2B_ACCUM: begin
        busy   = 1'b1;
        acc_en = in_valid;
        if (last_bit) state_d = S2B_DONE;
      end
      S2B_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S2B_IDLE;
      end
      default: state_d = S2B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S2B_IDLE;
      remaining_q <= '0;
      count       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S2B_IDLE && start) begin
        remaining_q <= len;
        if (len == '0) count <= '0;
      end else if (state_q == S2B_ACCUM && in_valid) begin
        remaining_q <= remaining_q - COUNT_WIDTH'(1);
        // acc has not yet absorbed the final bit, so add it here.
        if (last_bit) count <= acc_value + COUNT_WIDTH'(in);
      end
    end
  end

endmodule

// File: doc/sc_stream_to_binary.md
Name: sc_stream_to_binary

Overview:
- Downstream consumer of the stochastic n-input adder (sc_nadder): converts its unipolar output bitstream back to a binary value.
- Counts ones over a programmable window of valid stream bits, then presents the count with a one-cycle done pulse.
- Used as the result stage of stochastic datapaths and as the scoring stage in system-level benches.

Parameters:
- COUNT_WIDTH, 8, width of the window length and the result count; maximum window is 2^COUNT_WIDTH-1 bits.

Ports:
- clk    input   1            single clock; all state updates on rising edge
- rst    input   1            synchronous, active-high reset
- start  input   1            request a new window; honoured only in IDLE
- len    input   COUNT_WIDTH  window length in valid bits; sampled when start is accepted
- in     input   1            stochastic stream bit (sc_nadder out)
- in_valid input 1            in is meaningful this cycle
- busy   output  1            high in ACCUM and DONE
- done   output  1            one-cycle pulse: count updated
- count  output  COUNT_WIDTH  number of ones in last completed window; held until next done

Behaviour:
- Reset (sync, active-high, clk and rst only): state=IDLE, busy=0, done=0, count=0, internal accumulator and remaining counter=0. Reset has priority over every other input, including mid-window; a partial window is discarded and count returns to 0.
- States:
  - IDLE: busy=0. If start=1 at an edge, latch len into remaining and clear the accumulator.
    - len!=0: go to ACCUM.
    - len==0: go directly to DONE with count<=0.
  - ACCUM: busy=1.
    - Each edge with in_valid=1: acc<=acc+in, remaining<=remaining-1.
    - in_valid=0: acc and remaining hold (stall).
    - When in_valid=1 and remaining==1: count<=acc+in (includes the final bit) and go to DONE.
  - DONE: done=1, busy=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- start is ignored in ACCUM and DONE and does not queue.
- len changes after acceptance have no effect.
- in/in_valid are ignored outside ACCUM.
- Latency: done is visible in the cycle immediately after the edge that samples the last valid bit. Back-to-back windows are possible: start asserted during the DONE cycle is ignored; start in the following (IDLE) cycle is accepted.
- Width: acc never exceeds len ≤ 2^COUNT_WIDTH-1, so no overflow or saturation logic is needed. remaining never wraps, because the ACCUM exit occurs at 1.
- count is registered and stable between done pulses; it is not updated by a window aborted by rst (rst clears it to 0).
- done is never asserted in two consecutive cycles.

Decomposition:
- Shared package sc_pkg:
  - state encoding localparams SC_S2B_IDLE=2'd0, SC_S2B_ACCUM=2'd1, SC_S2B_DONE=2'd2.
  - the default COUNT_WIDTH constant, shared with the stream generators.
- Sub-module sc_ones_counter: COUNT_WIDTH up-counter with synchronous clear and enable. Increments when enable & in; reused by the future stochastic comparator/probability estimator.
- The FSM, remaining-down-counter and count register stay in sc_stream_to_binary.

Test Plan:
1. rst=1 for 2 cycles, then start=1 with len=8, in=1 and in_valid=1 for 8 cycles -> busy high from cycle after start; done pulses once, exactly 1 cycle after the 8th valid bit; count=8.
2. start with len=16, in alternating 1,0 with in_valid always 1 -> count=8; then an immediate new start with len=4 and in=0 -> count=0, done pulses once.
3. start with len=10, in=1, in_valid dropped for 3 cycles after the 4th bit -> done delayed by exactly 3 cycles vs. no-stall; count=10; bits presented while in_valid=0 are not counted.
4. start with len=6; during ACCUM assert start again with len=2 and change len -> the second start is ignored; window ends after 6 valid bits; busy stays high throughout.
5. start with len=0 -> done one cycle after acceptance, count=0, busy high for exactly that one DONE cycle.
6. Integration and reset: sc_nadder with x=8'hF0 and sel cycling 0..7 each cycle feeds in, window len=200 -> count=100. Repeat the run and assert rst after 50 bits -> next cycle busy=0, done=0, count=0. A fresh start with len=4 on all-ones input -> count=4.
